// File: rtl/sram_bus_arbiter.sv
// Shared external SRAM bus sequencer: arbitrates CPU and aux requesters and owns strobe timing.
// Optional build macro ARB_ROUNDROBIN_EN replaces fixed CPU priority with alternating priority.
module sram_bus_arbiter #(
  parameter int RD_STROBE = 2,
  parameter int WR_STROBE = 2
) (
  input  logic        clk6x,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rwn,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_done,
  input  logic        aux_req,
  input  logic        aux_rwn,
  input  logic [20:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  input  logic        aux_block,
  output logic        aux_done,
  output logic [7:0]  rdata,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [7:0]  mem_rdata,
  output logic        m1cs_n,
  output logic        mrd_n,
  output logic        mwr_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  logic [2:0] strobe_cnt;
  logic       rwn_q;
  logic       owner_aux;
  logic       aux_ok;
  logic       grant_cpu;
  logic       grant_aux;

  // Counter counts down to zero, so the reload value is one less than the strobe width.
  function automatic logic [2:0] strobe_reload(input logic rwn);
    return rwn ? 3'(RD_STROBE - 1) : 3'(WR_STROBE - 1);
  endfunction

`ifdef ARB_ROUNDROBIN_EN
  logic last_grant_aux;

  always_comb begin
    aux_ok    = aux_req && !aux_block;
    grant_cpu = cpu_req;
    grant_aux = aux_ok;
    if (cpu_req && aux_ok) begin
      grant_cpu = last_grant_aux;
      grant_aux = !last_grant_aux;
    end
  end

  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      last_grant_aux <= 1'b1;
    end else if (state == IDLE && (grant_cpu || grant_aux)) begin
      last_grant_aux <= grant_aux;
    end
  end
`else
  always_comb begin
    aux_ok    = aux_req && !aux_block;
    grant_cpu = cpu_req;
    grant_aux = !cpu_req && aux_ok;
  end
`endif

  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      strobe_cnt   <= 3'd0;
      rwn_q        <= 1'b1;
      owner_aux    <= 1'b0;
      m1cs_n       <= 1'b1;
      mrd_n        <= 1'b1;
      mwr_n        <= 1'b1;
      mem_wdata_oe <= 1'b0;
      cpu_done     <= 1'b0;
      aux_done     <= 1'b0;
      mem_addr     <= 21'd0;
      mem_wdata    <= 8'd0;
      rdata        <= 8'd0;
    end else begin
      cpu_done <= 1'b0;
      aux_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu || grant_aux) begin
            state     <= SETUP;
            owner_aux <= grant_aux;
            m1cs_n    <= 1'b0;
            if (grant_aux) begin
              mem_addr     <= aux_addr;
              mem_wdata    <= aux_wdata;
              rwn_q        <= aux_rwn;
              mem_wdata_oe <= !aux_rwn;
            end else begin
              mem_addr     <= cpu_addr;
              mem_wdata    <= cpu_wdata;
              rwn_q        <= cpu_rwn;
              mem_wdata_oe <= !cpu_rwn;
            end
          end
        end
        SETUP: begin
          state      <= STROBE;
          strobe_cnt <= strobe_reload(rwn_q);
          mrd_n      <= !rwn_q;
          mwr_n      <= rwn_q;
        end
        STROBE: begin
          // Read data is sampled on the edge that closes the strobe window.
          if (strobe_cnt == 3'd0) begin
            state    <= HOLD;
            mrd_n    <= 1'b1;
            mwr_n    <= 1'b1;
            cpu_done <= !owner_aux;
            aux_done <= owner_aux;
            if (rwn_q) begin
              rdata <= mem_rdata;
            end
          end else begin
            strobe_cnt <= strobe_cnt - 3'd1;
          end
        end
        HOLD: begin
          state        <= IDLE;
          m1cs_n       <= 1'b1;
          mem_wdata_oe <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed steps plus randomized accesses against a
// transaction-level model (arbitration order, access timing and memory contents).
module tb_sram_bus_arbiter;

  localparam int RD  = 2;
  localparam int WR  = 2;
  localparam int RD5 = 5;
`ifdef ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk6x = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_rwn = 1'b1, aux_req = 1'b0, aux_rwn = 1'b1, aux_block = 1'b0;
  logic [20:0] cpu_addr = '0, aux_addr = '0;
  logic [7:0]  cpu_wdata = '0, aux_wdata = '0;

  logic        cpu_done, aux_done, mem_wdata_oe, m1cs_n, mrd_n, mwr_n;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [20:0] mem_addr;

  logic        d5_cpu_done, d5_aux_done, d5_mem_wdata_oe, d5_m1cs_n, d5_mrd_n, d5_mwr_n;
  logic [7:0]  d5_rdata, d5_mem_wdata, d5_mem_rdata;
  logic [20:0] d5_mem_addr;

  logic [7:0]  sram [0:4095] = '{default: 8'h00};
  logic [7:0]  ref_mem [logic [20:0]];
  bit          last_cpu = 1'b0;

  int checks = 0, errors = 0, mon_checks = 0, mon_errs = 0;

  always #5 clk6x = ~clk6x;

  sram_bus_arbiter #(.RD_STROBE(RD), .WR_STROBE(WR)) u_dut (
    .clk6x(clk6x), .reset(reset),
    .cpu_req(cpu_req), .cpu_rwn(cpu_rwn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
    .aux_req(aux_req), .aux_rwn(aux_rwn), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_block(aux_block), .aux_done(aux_done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata),
    .m1cs_n(m1cs_n), .mrd_n(mrd_n), .mwr_n(mwr_n)
  );

  sram_bus_arbiter #(.RD_STROBE(RD5), .WR_STROBE(WR)) u_dut5 (
    .clk6x(clk6x), .reset(reset),
    .cpu_req(cpu_req), .cpu_rwn(cpu_rwn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(d5_cpu_done),
    .aux_req(aux_req), .aux_rwn(aux_rwn), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_block(aux_block), .aux_done(d5_aux_done), .rdata(d5_rdata),
    .mem_addr(d5_mem_addr), .mem_wdata(d5_mem_wdata), .mem_wdata_oe(d5_mem_wdata_oe), .mem_rdata(d5_mem_rdata),
    .m1cs_n(d5_m1cs_n), .mrd_n(d5_mrd_n), .mwr_n(d5_mwr_n)
  );

  // SRAM behaviour: asynchronous read, write while chip select and write strobe are low.
  assign mem_rdata    = sram[mem_addr[11:0]];
  assign d5_mem_rdata = d5_mem_addr[7:0] ^ 8'h5A;
  always @(posedge clk6x) if (!m1cs_n && !mwr_n) sram[mem_addr[11:0]] <= mem_wdata;

  always @(negedge clk6x) begin
    mon_checks <= mon_checks + 1;
    assert ((mrd_n || mwr_n) && (d5_mrd_n || d5_mwr_n) &&
            (!m1cs_n || (mrd_n && mwr_n)) && (!d5_m1cs_n || (d5_mrd_n && d5_mwr_n)) &&
            (!d5_mem_wdata_oe || !d5_m1cs_n))
    else begin
      mon_errs <= mon_errs + 1;
      $error("FAIL strobe_rules observed cs/rd/wr=%b%b%b d5=%b%b%b oe5=%b wd5=%h required no overlap, strobes inside cs",
             m1cs_n, mrd_n, mwr_n, d5_m1cs_n, d5_mrd_n, d5_mwr_n, d5_mem_wdata_oe, d5_mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_read(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [20:0] pool_addr(input int i);
    return 21'h0A000 + 21'(i) * 21'h111;
  endfunction

  // One transaction set: each enabled requester performs one access; checks order, timing and data.
  task automatic run_access(input bit c_en, input bit a_en, input bit c_rd, input bit a_rd,
                            input logic [20:0] c_a, input logic [20:0] a_a,
                            input logic [7:0] c_w, input logic [7:0] a_w, input bit blk_mid);
    bit first_cpu, c_pend, a_pend, cur_cpu, cur_rd;
    int k, k_last, served, n, cs_low, rd_low, wr_low, oe_high, bad_bus, stray;
    int exp_cs, exp_rd, exp_wr, exp_oe;
    first_cpu = (c_en && a_en) ? (RR ? !last_cpu : 1'b1) : c_en;
    exp_cs = 0; exp_rd = 0; exp_wr = 0; exp_oe = 0;
    if (c_en) begin
      n = c_rd ? RD : WR; exp_cs += n + 2;
      if (c_rd) exp_rd += n; else begin exp_wr += n; exp_oe += n + 2; end
    end
    if (a_en) begin
      n = a_rd ? RD : WR; exp_cs += n + 2;
      if (a_rd) exp_rd += n; else begin exp_wr += n; exp_oe += n + 2; end
    end
    cpu_req = c_en; cpu_rwn = c_rd; cpu_addr = c_a; cpu_wdata = c_w;
    aux_req = a_en; aux_rwn = a_rd; aux_addr = a_a; aux_wdata = a_w; aux_block = 1'b0;
    c_pend = c_en; a_pend = a_en;
    k = 0; k_last = 0; served = 0;
    cs_low = 0; rd_low = 0; wr_low = 0; oe_high = 0; bad_bus = 0; stray = 0;
    while ((c_pend || a_pend) && k < 60) begin
      @(posedge clk6x); #1; k++;
      cur_cpu = (c_pend && a_pend) ? first_cpu : c_pend;
      if (k == 1) check("setup_start", 32'(m1cs_n), 0);
      if (blk_mid && k == 2) aux_block = 1'b1;
      if (!m1cs_n) cs_low++;
      if (!mrd_n) rd_low++;
      if (!mwr_n) wr_low++;
      if (mem_wdata_oe) oe_high++;
      if ((!mrd_n || !mwr_n) && (mem_addr !== (cur_cpu ? c_a : a_a))) bad_bus++;
      if (!mwr_n && ((mem_wdata !== (cur_cpu ? c_w : a_w)) || !mem_wdata_oe)) bad_bus++;
      if ((cpu_done && !c_pend) || (aux_done && !a_pend)) stray++;
      if (cpu_done || aux_done) begin
        check("done_owner", 32'({cpu_done, aux_done}), 32'({cur_cpu, !cur_cpu}));
        cur_rd = cur_cpu ? c_rd : a_rd;
        n = cur_rd ? RD : WR;
        check("done_latency", k - k_last, (served == 0) ? n + 2 : n + 3);
        if (cur_rd) check("rdata", 32'(rdata), 32'(ref_read(cur_cpu ? c_a : a_a)));
        else ref_mem[cur_cpu ? c_a : a_a] = cur_cpu ? c_w : a_w;
        last_cpu = cur_cpu; served++; k_last = k;
        if (cur_cpu) begin c_pend = 1'b0; cpu_req = 1'b0; end
        else begin a_pend = 1'b0; aux_req = 1'b0; end
      end
    end
    check("timeout", 32'({c_pend, a_pend}), 0);
    @(posedge clk6x); #1;
    aux_block = 1'b0;
    check("return_idle", 32'({m1cs_n, mrd_n, mwr_n, mem_wdata_oe, cpu_done, aux_done}), 32'b111000);
    check("cs_cycles", cs_low, exp_cs);
    check("mrd_cycles", rd_low, exp_rd);
    check("mwr_cycles", wr_low, exp_wr);
    check("oe_cycles", oe_high, exp_oe);
    check("bus_values", bad_bus, 0);
    check("stray_done", stray, 0);
  endtask

  initial begin
    int k, dn, cs, rd5, kd, sel;
    bit got;

    // Reset values
    repeat (2) @(posedge clk6x);
    #1;
    check("rst_strobes", 32'({m1cs_n, mrd_n, mwr_n}), 32'b111);
    check("rst_oe", 32'(mem_wdata_oe), 0);
    check("rst_done", 32'({cpu_done, aux_done}), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    reset = 1'b0;

    // CPU write then read back; aux write then read back
    run_access(1, 0, 0, 0, 21'h00010, '0, 8'h12, 8'h00, 0);
    run_access(1, 0, 1, 0, 21'h00010, '0, 8'h00, 8'h00, 0);
    check("cpu_rd_value", 32'(rdata), 32'h12);
    run_access(0, 1, 0, 0, '0, 21'h1FE50, 8'h00, 8'hDE, 0);
    run_access(0, 1, 0, 1, '0, 21'h1FE50, 8'h00, 8'h00, 0);
    check("aux_rd_value", 32'(rdata), 32'hDE);

    // Simultaneous requests after a CPU grant
    run_access(1, 0, 1, 0, 21'h00010, '0, 8'h00, 8'h00, 0);
    run_access(1, 1, 1, 1, 21'h00010, 21'h1FE50, 8'h00, 8'h00, 0);

    // aux_block inhibits grants, then aux_block raised mid-access does not abort it
    aux_req = 1'b1; aux_rwn = 1'b1; aux_addr = 21'h1FE50; aux_block = 1'b1;
    cs = 0;
    repeat (10) begin
      @(posedge clk6x); #1;
      if (!m1cs_n || !mrd_n || !mwr_n || aux_done) cs++;
    end
    check("block_no_grant", cs, 0);
    run_access(0, 1, 0, 1, '0, 21'h1FE50, 8'h00, 8'h00, 0);
    run_access(0, 1, 0, 0, '0, 21'h1FE60, 8'h00, 8'h77, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      run_access(sel[0], sel[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pool_addr($urandom_range(0, 7)), pool_addr($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom), 0);
    end

    // Reset in the middle of a CPU write strobe
    cpu_req = 1'b1; cpu_rwn = 1'b0; cpu_addr = 21'h00300; cpu_wdata = 8'hA5;
    k = 0;
    while (mwr_n && k < 10) begin
      @(posedge clk6x); #1; k++;
    end
    check("abort_reach_strobe", 32'(mwr_n), 0);
    #2 reset = 1'b1;
    #1;
    check("abort_async_release", 32'({mwr_n, m1cs_n, mem_wdata_oe}), 32'b110);
    cpu_req = 1'b0;
    dn = 0;
    repeat (3) begin
      @(posedge clk6x); #1;
      if (cpu_done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_rdata_cleared", 32'(rdata), 0);
    reset = 1'b0;
    last_cpu = 1'b0;
    run_access(1, 0, 0, 0, 21'h00300, '0, 8'h3C, 8'h00, 0);
    run_access(1, 0, 1, 0, 21'h00300, '0, 8'h00, 8'h00, 0);
    check("post_reset_read", 32'(rdata), 32'h3C);
    repeat (10) @(posedge clk6x);
    #1;

    // Five-cycle read strobe
    cpu_req = 1'b1; cpu_rwn = 1'b1; cpu_addr = 21'h00123;
    k = 0; rd5 = 0; kd = 0; got = 1'b0; dn = 0;
    while (!got && k < 30) begin
      @(posedge clk6x); #1; k++;
      if (!d5_mrd_n) rd5++;
      if (d5_aux_done) dn++;
      if (d5_cpu_done) begin got = 1'b1; kd = k; end
    end
    cpu_req = 1'b0;
    check("s5_latency", kd, RD5 + 2);
    check("s5_mrd_cycles", rd5, RD5);
    check("s5_rdata", 32'(d5_rdata), 32'h79);
    check("s5_no_aux_done", dn, 0);
    repeat (12) @(posedge clk6x);
    #1;
    check("monitor_ran", 32'(mon_checks > 100), 1);
    check("monitor_errors", mon_errs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
